pixel_write_buffer: RTL and testbench
=====================================

# pixel_write_buffer

Consumer end of the line-drawer coordinate stream. Accepts pixel coordinates (x, y, colour) from the coordinate generator through a valid/ready handshake and buffers them in a FIFO. It clips off-screen points, converts each point to a linear framebuffer address and issues writes to the VGA framebuffer port under framebuffer back-pressure. It also performs a full-screen clear on request, after draining all pending pixels.

## Interface
- DEPTH, 16, FIFO entries (power of two, ≥2)
- WIDTH, 640, visible columns
- HEIGHT, 480, visible rows
- ADDR_W, 19, framebuffer address width (must hold WIDTH*HEIGHT-1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pix_valid  in  1  input pixel present
- pix_ready  out  1  block can accept a pixel this cycle
- pix_x  in  10  pixel column
- pix_y  in  9  pixel row
- pix_color  in  1  pixel colour
- clear_req  in  1  single-cycle request to clear the whole screen
- clear_busy  out  1  clear sequence in progress
- fb_ready  in  1  framebuffer accepts a write this cycle
- fb_we  out  1  write request, registered
- fb_addr  out  ADDR_W  linear address, registered
- fb_data  out  1  write colour, registered
- drop_count  out  16  clipped-pixel count, saturating
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- Input handshake: a pixel transfers in any cycle with pix_valid && pix_ready.
- pix_ready = !fifo_full && state==RUN. It is combinational. There is no push while full, even if a pop occurs in the same cycle.
- Clipping: a transferred pixel with x ≥ WIDTH or y ≥ HEIGHT is consumed but not stored. drop_count increments by 1 and saturates at 16'hFFFF.
- FIFO: first-in first-out. Push and pop may happen in the same cycle when the FIFO is neither full nor empty; fifo_level is then unchanged.
- Output stage: a one-entry register (fb_we/fb_addr/fb_data).
  - A write completes in a cycle with fb_we && fb_ready.
  - While fb_we=1 and fb_ready=0, addr and data hold stable.
  - The register reloads from the FIFO head when it is empty or completing this cycle and the FIFO is non-empty. Otherwise fb_we drops to 0.
- Address arithmetic: fb_addr = y*WIDTH + x, computed unsigned at ADDR_W bits, with no overflow for in-range points.
- FSM states:
  - RUN: normal operation. clear_req=1 → DRAIN.
  - DRAIN: pix_ready=0. Remains until the FIFO is empty and the last pixel write completes → CLEAR with sweep counter=0.
  - CLEAR: output stage issues addr=counter, data=0. The counter increments on each completed write. Completion of addr WIDTH*HEIGHT-1 → RUN.
- clear_busy = (state≠RUN).
- clear_req is ignored outside RUN.
- Pixel order is preserved in all states. No pixel accepted before clear_req is written after any clear write.

## Timing
- Reset values: fb_we=0, fb_addr=0, fb_data=0, clear_busy=0, drop_count=0, fifo_level=0, state=RUN. pix_ready=1 during and after reset.
- Latency: a pixel accepted in cycle C into an empty FIFO with an idle output stage gives fb_we=1 in cycle C+2.
- Throughput: 1 write per cycle with fb_ready held high, in both RUN and CLEAR.
- With clear_req in cycle C: clear_busy=1 and pix_ready=0 from C+1. clear_busy returns to 0 in the cycle after the last clear write completes.
- Clear duration with fb_ready=1 and nothing pending: WIDTH*HEIGHT cycles of fb_we=1.
- Reset asserted mid-operation: immediate return to reset values. FIFO contents, pending write and clear progress are discarded with no partial write afterward.
- fifo_level updates one cycle after the push/pop edge, i.e. it is registered.

## Test plan
- Single pixel (3,2,1) accepted in cycle C, fb_ready=1 → in C+2 fb_we=1, fb_addr=1283, fb_data=1, then fb_we=0 in C+3.
- Push (640,0,1), (0,480,1), (639,479,1) → drop_count=2; exactly one write, fb_addr=307199.
- fb_ready=0, push 17 pixels (x=0..16, y=0) → pix_ready=0 after 17th accept, fifo_level=16, fb_addr=0 held. Release fb_ready → 17 writes at addr 0..16 in order on consecutive cycles.
- Push 2 pixels, then clear_req → 2 pixel writes, then 307200 writes addr 0..307199 with data 0. pix_ready=0 and clear_busy=1 throughout; both return to 1 and 0 respectively afterward. A second clear_req mid-clear has no effect.
- Reset asserted during CLEAR at counter 1000 → fb_we=0, clear_busy=0, fifo_level=0 immediately. Next pixel (5,0,1) is written at addr 5.
- Feed 65540 clipped pixels → drop_count saturates at 65535.

Source files
------------

// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: clips and queues incoming coordinates, issues linear framebuffer
// writes under back-pressure, and runs a drain-then-sweep screen clear on request.
module pixel_write_buffer #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned ADDR_W = 19
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [9:0]                   pix_x,
    input  logic [8:0]                   pix_y,
    input  logic                         pix_color,
    input  logic                         clear_req,
    output logic                         clear_busy,
    input  logic                         fb_ready,
    output logic                         fb_we,
    output logic [ADDR_W-1:0]            fb_addr,
    output logic                         fb_data,
    output logic [15:0]                  drop_count,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned       PTR_W     = $clog2(DEPTH);
    localparam int unsigned       LVL_W     = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W:0]   CLR_END   = (ADDR_W + 1)'(WIDTH * HEIGHT);

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

    typedef struct packed {
        logic              color;
        logic [ADDR_W-1:0] addr;
    } entry_t;

    state_t            state, state_next;
    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [LVL_W-1:0]  count;
    logic [ADDR_W:0]   clr_cnt;
    logic [ADDR_W-1:0] pix_addr;
    logic              fifo_full, fifo_empty, in_range, accept, push, pop;
    logic              out_free, clear_issue, clear_done;

    assign fifo_full   = (count == LVL_W'(DEPTH));
    assign fifo_empty  = (count == '0);
    assign pix_ready   = !fifo_full && (state == RUN);
    assign clear_busy  = (state != RUN);
    assign fifo_level  = count;

    assign in_range    = (32'(pix_x) < WIDTH) && (32'(pix_y) < HEIGHT);
    assign accept      = pix_valid && pix_ready;
    assign push        = accept && in_range;
    assign pix_addr    = ADDR_W'(pix_y) * ADDR_W'(WIDTH) + ADDR_W'(pix_x);

    // The output register may take a new word when it is idle or retiring its current one.
    assign out_free    = !fb_we || fb_ready;
    assign pop         = out_free && !fifo_empty && (state != CLEAR);
    assign clear_issue = out_free && (state == CLEAR) && (clr_cnt < CLR_END);
    assign clear_done  = (state == CLEAR) && fb_we && fb_ready && (fb_addr == LAST_ADDR);
    assign head        = mem[rd_ptr];

    // NOTE: the storage array carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{color: pix_color, addr: pix_addr};
    end

    // NOTE: all clocked state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_count <= '0;
        end else if (accept && !in_range && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // NOTE: next-state gets its default before the case, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (clear_req) state_next = DRAIN;
            DRAIN:   if (fifo_empty && out_free) state_next = CLEAR;
            CLEAR:   if (clear_done) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Sweep counter holds the next address to issue; it restarts whenever the sweep is inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                clr_cnt <= '0;
        else if (state != CLEAR)  clr_cnt <= '0;
        else if (clear_issue)     clr_cnt <= clr_cnt + (ADDR_W + 1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fb_we   <= 1'b0;
            fb_addr <= '0;
            fb_data <= 1'b0;
        end else if (pop) begin
            fb_we   <= 1'b1;
            fb_addr <= head.addr;
            fb_data <= head.color;
        end else if (clear_issue) begin
            fb_we   <= 1'b1;
            fb_addr <= clr_cnt[ADDR_W-1:0];
            fb_data <= 1'b0;
        end else if (out_free) begin
            fb_we   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench for pixel_write_buffer on a reduced 40x30 screen: directed steps plus
// randomized traffic scored against a queue of expected framebuffer writes.
module tb_pixel_write_buffer;

    localparam int W     = 40;
    localparam int H     = 30;
    localparam int N     = W * H;
    localparam int AW    = 11;
    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH + 1);

    typedef struct {
        logic [AW-1:0] addr;
        logic          data;
        logic          clr;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid, pix_ready, pix_color, clear_req, clear_busy, fb_ready;
    logic [9:0]    pix_x;
    logic [8:0]    pix_y;
    logic          fb_we, fb_data;
    logic [AW-1:0] fb_addr;
    logic [15:0]   drop_count;
    logic [LW-1:0] fifo_level;

    wr_t exp_q[$];
    int  passed = 0;
    int  total  = 0;
    int  model_drops = 0;
    bit  model_busy  = 1'b0;
    bit  accepted    = 1'b0;
    int  wr_cnt      = 0;
    int  clr_wr_cnt  = 0;

    always #5 clk = ~clk;

    pixel_write_buffer #(.DEPTH(DEPTH), .WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
        .clear_req(clear_req), .clear_busy(clear_busy),
        .fb_ready(fb_ready), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .drop_count(drop_count), .fifo_level(fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // One clock: score the handshakes of the coming edge at negedge, then step past the edge.
    task automatic cycle();
        bit  req_ok;
        wr_t e;
        @(negedge clk);
        accepted = 1'b0;
        req_ok   = clear_req && !model_busy && !reset;
        if (model_busy) check("ready_low_while_busy", 32'(pix_ready), 32'(0));
        if (fb_we && fb_ready) begin
            wr_cnt++;
            check("write_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(fb_addr), 32'(e.addr));
                check("wr_data", 32'(fb_data), 32'(e.data));
                if (e.clr) clr_wr_cnt++;
                if (e.clr && e.addr == AW'(N - 1)) model_busy = 1'b0;
            end
        end
        if (pix_valid && pix_ready && !reset) begin
            accepted = 1'b1;
            if (int'(pix_x) < W && int'(pix_y) < H)
                exp_q.push_back('{addr: AW'(int'(pix_y) * W + int'(pix_x)), data: pix_color, clr: 1'b0});
            else if (model_drops < 65535)
                model_drops++;
        end
        if (req_ok) begin
            model_busy = 1'b1;
            for (int i = 0; i < N; i++) exp_q.push_back('{addr: AW'(i), data: 1'b0, clr: 1'b1});
        end
        @(posedge clk);
        #1;
        check("clear_busy", 32'(clear_busy), 32'(model_busy));
    endtask

    task automatic push_pixel(input int x, input int y, input logic c);
        int n = 0;
        pix_x = 10'(x); pix_y = 9'(y); pix_color = c; pix_valid = 1'b1;
        do begin
            cycle();
            n++;
        end while (!accepted && n < 50);
        pix_valid = 1'b0;
        check("push_accept", 32'(accepted), 32'(1));
    endtask

    task automatic wait_idle(input int max_cycles);
        int n = 0;
        while ((exp_q.size() != 0 || fb_we || clear_busy) && n < max_cycles) begin
            cycle();
            n++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'(0));
        check("drain_fb_we_low", 32'(fb_we), 32'(0));
    endtask

    initial begin
        int base, cnt, n;
        bit found;

        reset = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; pix_color = 1'b0;
        clear_req = 1'b0; fb_ready = 1'b1;
        #1;
        check("rst_fb_we", 32'(fb_we), 32'(0));
        check("rst_fb_addr", 32'(fb_addr), 32'(0));
        check("rst_fb_data", 32'(fb_data), 32'(0));
        check("rst_clear_busy", 32'(clear_busy), 32'(0));
        check("rst_drop_count", 32'(drop_count), 32'(0));
        check("rst_fifo_level", 32'(fifo_level), 32'(0));
        check("rst_pix_ready", 32'(pix_ready), 32'(1));
        repeat (2) cycle();
        reset = 1'b0;
        cycle();

        // Single pixel latency: accept in C, write visible in C+2, gone in C+3.
        pix_x = 10'd3; pix_y = 9'd2; pix_color = 1'b1; pix_valid = 1'b1;
        cycle();
        pix_valid = 1'b0;
        check("lat_accept", 32'(accepted), 32'(1));
        check("lat_c1_we", 32'(fb_we), 32'(0));
        cycle();
        check("lat_c2_we", 32'(fb_we), 32'(1));
        check("lat_c2_addr", 32'(fb_addr), 32'(2 * W + 3));
        check("lat_c2_data", 32'(fb_data), 32'(1));
        cycle();
        check("lat_c3_we", 32'(fb_we), 32'(0));

        // Clipping at both edges and the last visible pixel.
        base = wr_cnt;
        push_pixel(W, 0, 1'b1);
        push_pixel(0, H, 1'b1);
        push_pixel(W - 1, H - 1, 1'b1);
        wait_idle(50);
        check("clip_drop_count", 32'(drop_count), 32'(model_drops));
        check("clip_one_write", 32'(wr_cnt - base), 32'(1));

        // Back-pressure: fill the FIFO behind a stalled output register.
        fb_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) push_pixel(i, 0, 1'b1);
        check("full_pix_ready", 32'(pix_ready), 32'(0));
        check("full_fifo_level", 32'(fifo_level), 32'(exp_q.size() - 1));
        check("full_fb_we", 32'(fb_we), 32'(1));
        check("full_fb_addr", 32'(fb_addr), 32'(0));
        pix_x = 10'd20; pix_y = 9'd0; pix_valid = 1'b1;
        cycle();
        pix_valid = 1'b0;
        check("full_no_accept", 32'(accepted), 32'(0));
        repeat (3) cycle();
        check("stall_addr_hold", 32'(fb_addr), 32'(0));
        fb_ready = 1'b1;
        base = wr_cnt;
        repeat (DEPTH + 1) cycle();
        check("burst_consecutive", 32'(wr_cnt - base), 32'(DEPTH + 1));
        check("burst_end_we", 32'(fb_we), 32'(0));
        check("burst_end_level", 32'(fifo_level), 32'(0));

        // Clear after two pending pixels; a repeated request mid-sweep must be ignored.
        fb_ready = 1'b0;
        push_pixel(7, 1, 1'b1);
        push_pixel(8, 1, 1'b0);
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        fb_ready  = 1'b1;
        check("clr_busy_c1", 32'(clear_busy), 32'(1));
        check("clr_ready_c1", 32'(pix_ready), 32'(0));
        base = clr_wr_cnt;
        n = 0;
        while ((model_busy || clear_busy) && n < 4000) begin
            clear_req = (n == 500);
            cycle();
            n++;
        end
        clear_req = 1'b0;
        check("clr_write_count", 32'(clr_wr_cnt - base), 32'(N));
        check("clr_end_ready", 32'(pix_ready), 32'(1));
        check("clr_end_queue", 32'(exp_q.size()), 32'(0));

        // Idle clear: exactly one fb_we cycle per screen pixel while busy.
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        cnt = 0; n = 0;
        while (clear_busy && n < 4000) begin
            if (fb_we) cnt++;
            cycle();
            n++;
        end
        check("clr_idle_we_cycles", 32'(cnt), 32'(N));

        // Randomized traffic with stalls and one clear request.
        for (int i = 0; i < 3000; i++) begin
            pix_valid = 1'($urandom_range(0, 1));
            pix_x     = 10'($urandom_range(0, W + 3));
            pix_y     = 9'($urandom_range(0, H + 2));
            pix_color = 1'($urandom_range(0, 1));
            fb_ready  = ($urandom_range(0, 3) != 0);
            clear_req = (i == 1000);
            cycle();
        end
        pix_valid = 1'b0; clear_req = 1'b0; fb_ready = 1'b1;
        wait_idle(4000);
        check("rand_drop_count", 32'(drop_count), 32'(model_drops));
        check("rand_fifo_level", 32'(fifo_level), 32'(0));

        // Asynchronous reset in the middle of a sweep.
        clear_req = 1'b1;
        cycle();
        clear_req = 1'b0;
        found = 1'b0; n = 0;
        while (!found && n < 3000) begin
            cycle();
            n++;
            found = fb_we && (fb_addr == AW'(1000));
        end
        check("rst_mid_reached", 32'(found), 32'(1));
        #2 reset = 1'b1;
        #1;
        exp_q.delete();
        model_busy  = 1'b0;
        model_drops = 0;
        check("rst_mid_fb_we", 32'(fb_we), 32'(0));
        check("rst_mid_busy", 32'(clear_busy), 32'(0));
        check("rst_mid_level", 32'(fifo_level), 32'(0));
        check("rst_mid_ready", 32'(pix_ready), 32'(1));
        cycle();
        reset = 1'b0;
        base = wr_cnt;
        push_pixel(5, 0, 1'b1);
        wait_idle(50);
        check("rst_next_one_write", 32'(wr_cnt - base), 32'(1));

        // Drop counter saturation.
        pix_valid = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            pix_x = 10'($urandom_range(W, 1023));
            pix_y = 9'($urandom_range(0, 511));
            cycle();
        end
        pix_valid = 1'b0;
        check("drop_saturate", 32'(drop_count), 32'(model_drops));
        check("drop_no_writes", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
